regfile_sequencer: RTL and testbench

//   Instruction sequencer for the dual-read register file and ALU. Fetches 32-bit instruction words

---
 rtl/regfile_sequencer.sv | 135 +++++++++++++
 tb/tb_regfile_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Instruction sequencer: fetches over req/valid, decodes, and drives register-file control for one EXEC cycle.
// Optional single-step mode (PAUSE after each executed instruction) is enabled by defining REGFILE_SEQ_STEP_EN.
module regfile_sequencer #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef REGFILE_SEQ_STEP_EN
  input  logic                  step,
`endif
  output logic                  instr_req,
  output logic [PC_WIDTH-1:0]   instr_addr,
  input  logic                  instr_valid,
  input  logic [31:0]           instr_data,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [3:0]            addr_1,
  output logic [3:0]            addr_2,
  output logic [3:0]            addr_3,
  output logic [DATA_WIDTH-1:0] imm_data,
  output logic                  wr_sel_imm,
  input  logic [DATA_WIDTH-1:0] read_data_reg,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, HALTED
`ifdef REGFILE_SEQ_STEP_EN
    , PAUSE
`endif
  } state_e;

  typedef enum logic [2:0] {K_NOP, K_ALU, K_WR, K_RD, K_HALT} kind_e;

`ifdef REGFILE_SEQ_STEP_EN
  localparam state_e POST_EXEC = PAUSE;
`else
  localparam state_e POST_EXEC = FETCH;
`endif

  state_e              state, state_n;
  kind_e               kind, kind_in;
  logic [PC_WIDTH-1:0] pc;
  logic                unused_rsvd;

  assign unused_rsvd = ^instr_data[3:0];

  always_comb begin
    kind_in = K_NOP;
    if (instr_data[31:28] == 4'b0001)      kind_in = K_ALU;
    else if (instr_data[31:24] == 8'h21)   kind_in = K_WR;
    else if (instr_data[31:24] == 8'h22)   kind_in = K_RD;
    else if (instr_data[31:24] == 8'hFF)   kind_in = K_HALT;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, HALTED: if (start) state_n = FETCH;
      FETCH:        if (instr_valid) state_n = EXEC;
      EXEC:         state_n = (kind == K_HALT) ? HALTED : POST_EXEC;
`ifdef REGFILE_SEQ_STEP_EN
      PAUSE:        if (step) state_n = FETCH;
`endif
      default:      state_n = IDLE;
    endcase
  end

  // Control outputs are registered on the FETCH->EXEC edge so they are live for exactly the EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      kind       <= K_NOP;
      pc         <= '0;
      opcode     <= '0;
      addr_1     <= '0;
      addr_2     <= '0;
      addr_3     <= '0;
      imm_data   <= '0;
      wr_sel_imm <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state      <= state_n;
      opcode     <= '0;
      addr_1     <= '0;
      addr_2     <= '0;
      addr_3     <= '0;
      imm_data   <= '0;
      wr_sel_imm <= 1'b0;
      rd_valid   <= 1'b0;
      if ((state == IDLE || state == HALTED) && start)
        pc <= '0;
      if (state == EXEC && kind != K_HALT)
        pc <= pc + PC_WIDTH'(1);
      if (state == FETCH && instr_valid) begin
        kind <= kind_in;
        case (kind_in)
          K_ALU: begin
            opcode <= DATA_WIDTH'(instr_data[31:16]);
            addr_1 <= instr_data[15:12];
            addr_2 <= instr_data[11:8];
            addr_3 <= instr_data[7:4];
          end
          K_WR: begin
            opcode     <= DATA_WIDTH'(instr_data[31:16]);
            addr_3     <= instr_data[19:16];
            imm_data   <= DATA_WIDTH'(instr_data[15:0]);
            wr_sel_imm <= 1'b1;
          end
          K_RD: begin
            opcode <= DATA_WIDTH'(instr_data[31:16]);
            addr_3 <= instr_data[19:16];
          end
          default: ;
        endcase
      end
      if (state == EXEC && kind == K_RD) begin
        rd_data  <= read_data_reg;
        rd_valid <= 1'b1;
      end
    end
  end

  // Combinational from state so an asynchronous reset drops the request immediately.
  assign instr_req  = (state == FETCH);
  assign instr_addr = pc;
  assign busy       = (state != IDLE) && (state != HALTED);
  assign halted     = (state == HALTED);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: main instance (PC_WIDTH=8) plus a PC_WIDTH=2 instance for wrap.
module tb_regfile_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, instr_valid;
  logic [31:0] instr_data;
  logic [15:0] read_data_reg;
  logic        instr_req, wr_sel_imm, rd_valid, busy, halted;
  logic [7:0]  instr_addr;
  logic [15:0] opcode, imm_data, rd_data;
  logic [3:0]  addr_1, addr_2, addr_3;

  logic        start2, instr_valid2;
  logic [31:0] instr_data2;
  logic        instr_req2, wr_sel_imm2, rd_valid2, busy2, halted2;
  logic [1:0]  instr_addr2;
  logic [15:0] opcode2, imm_data2, rd_data2;
  logic [3:0]  addr_12, addr_22, addr_32;
`ifdef REGFILE_SEQ_STEP_EN
  logic        step, step2;
`endif

  logic [31:0] mem [256];
  int          wait_n, wcnt;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(.PC_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef REGFILE_SEQ_STEP_EN
    .step(step),
`endif
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid), .instr_data(instr_data),
    .opcode(opcode), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3), .imm_data(imm_data),
    .wr_sel_imm(wr_sel_imm), .read_data_reg(read_data_reg), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .halted(halted));

  regfile_sequencer #(.PC_WIDTH(2), .DATA_WIDTH(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
`ifdef REGFILE_SEQ_STEP_EN
    .step(step2),
`endif
    .instr_req(instr_req2), .instr_addr(instr_addr2), .instr_valid(instr_valid2), .instr_data(instr_data2),
    .opcode(opcode2), .addr_1(addr_12), .addr_2(addr_22), .addr_3(addr_32), .imm_data(imm_data2),
    .wr_sel_imm(wr_sel_imm2), .read_data_reg(16'h0000), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .busy(busy2), .halted(halted2));

  // Memory responder: waits wait_n cycles per fetch, then presents the word; second instance is zero-wait NOPs.
  task automatic mem_drive();
    if (instr_req) begin
      if (wcnt < wait_n) begin instr_valid = 1'b0; wcnt++; end
      else begin instr_valid = 1'b1; instr_data = mem[instr_addr]; end
    end else begin
      instr_valid = 1'b0; wcnt = 0;
    end
    instr_valid2 = instr_req2;
    instr_data2  = 32'h0000_0000;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    mem_drive();
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (!halted && n < 40) begin tick(); n++; end
    total++;
    if (halted !== 1'b1) begin
      bad++; $display("FAIL %s_halt: halted=%0b after %0d cycles, want 1", name, halted, n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFF00_0000;
    #2;
    total++;
    if ({instr_req, busy, halted, rd_valid, wr_sel_imm} !== 5'b0 || instr_addr !== 8'h00 ||
        opcode !== 16'h0 || imm_data !== 16'h0 || rd_data !== 16'h0 || {addr_1, addr_2, addr_3} !== 12'h0) begin
      bad++; $display("FAIL reset_state: req=%0b busy=%0b addr=%0h op=%0h, want all 0", instr_req, busy, instr_addr, opcode);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_drive();
  endtask

  task automatic test_write_halt();
    mem[0] = 32'h2103_1234; mem[1] = 32'hFF00_0000;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (instr_req !== 1'b1 || instr_addr !== 8'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL wr_fetch: req=%0b addr=%0d busy=%0b, want 1 0 1", instr_req, instr_addr, busy);
    end
    tick();
    total++;
    if (opcode !== 16'h2103 || addr_3 !== 4'd3 || imm_data !== 16'h1234 || wr_sel_imm !== 1'b1) begin
      bad++; $display("FAIL wr_exec: op=%0h a3=%0d imm=%0h sel=%0b, want 2103 3 1234 1", opcode, addr_3, imm_data, wr_sel_imm);
    end
    tick();
    total++;
    if (opcode !== 16'h0 || wr_sel_imm !== 1'b0 || imm_data !== 16'h0) begin
      bad++; $display("FAIL wr_after: op=%0h sel=%0b imm=%0h, want 0 0 0", opcode, wr_sel_imm, imm_data);
    end
    run_to_halt("wr");
    total++;
    if (instr_addr !== 8'd1 || busy !== 1'b0 || opcode !== 16'h0) begin
      bad++; $display("FAIL wr_halted: addr=%0d busy=%0b op=%0h, want 1 0 0", instr_addr, busy, opcode);
    end
  endtask

  task automatic test_alu();
    mem[0] = 32'h1000_1230; mem[1] = 32'hFF00_0000;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (opcode !== 16'h0 || halted !== 1'b0 || instr_addr !== 8'd0) begin
      bad++; $display("FAIL alu_before: op=%0h halted=%0b addr=%0d, want 0 0 0", opcode, halted, instr_addr);
    end
    tick();
    total++;
    if (opcode !== 16'h1000 || addr_1 !== 4'd1 || addr_2 !== 4'd2 || addr_3 !== 4'd3 || wr_sel_imm !== 1'b0) begin
      bad++; $display("FAIL alu_exec: op=%0h a=%0d/%0d/%0d sel=%0b, want 1000 1/2/3 0", opcode, addr_1, addr_2, addr_3, wr_sel_imm);
    end
    tick();
    total++;
    if (opcode !== 16'h0 || {addr_1, addr_2, addr_3} !== 12'h0) begin
      bad++; $display("FAIL alu_after: op=%0h addrs=%0h, want 0 0", opcode, {addr_1, addr_2, addr_3});
    end
    run_to_halt("alu");
  endtask

  task automatic test_read();
    mem[0] = 32'h2205_0000; mem[1] = 32'hFF00_0000;
    read_data_reg = 16'hBEEF;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    total++;
    if (addr_3 !== 4'd5 || opcode !== 16'h2205 || rd_valid !== 1'b0 || wr_sel_imm !== 1'b0) begin
      bad++; $display("FAIL rd_exec: a3=%0d op=%0h rdv=%0b sel=%0b, want 5 2205 0 0", addr_3, opcode, rd_valid, wr_sel_imm);
    end
    read_data_reg = 16'hBEEF;
    tick();
    read_data_reg = 16'h0000;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || addr_3 !== 4'd0) begin
      bad++; $display("FAIL rd_capture: rdv=%0b rd=%0h a3=%0d, want 1 beef 0", rd_valid, rd_data, addr_3);
    end
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 16'hBEEF) begin
      bad++; $display("FAIL rd_pulse: rdv=%0b rd=%0h, want 0 beef", rd_valid, rd_data);
    end
    run_to_halt("rd");
  endtask

  task automatic test_wait();
    mem[0] = 32'h1000_1230; mem[1] = 32'hFF00_0000;
    wait_n = 3;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (instr_req !== 1'b1 || instr_addr !== 8'd0 || instr_valid !== 1'b0 || opcode !== 16'h0) begin
        bad++; $display("FAIL wait_hold%0d: req=%0b addr=%0d op=%0h, want 1 0 0", i, instr_req, instr_addr, opcode);
      end
      start = (i == 0);
      tick();
    end
    start = 1'b0;
    total++;
    if (instr_req !== 1'b1 || instr_addr !== 8'd0) begin
      bad++; $display("FAIL wait_last: req=%0b addr=%0d, want 1 0", instr_req, instr_addr);
    end
    tick();
    total++;
    if (opcode !== 16'h1000) begin
      bad++; $display("FAIL wait_exec: op=%0h, want 1000", opcode);
    end
    instr_valid = 1'b1; instr_data = 32'h2105_5555;
    tick();
    total++;
    if (opcode !== 16'h0 || wr_sel_imm !== 1'b0 || instr_addr !== 8'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL wait_stray: op=%0h sel=%0b addr=%0d busy=%0b, want 0 0 1 1", opcode, wr_sel_imm, instr_addr, busy);
    end
    run_to_halt("wait");
    wait_n = 0;
  endtask

  task automatic test_reset_mid();
    mem[0] = 32'h0000_0000; mem[1] = 32'hFF00_0000;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    wait_n = 5;
    tick();
`ifdef REGFILE_SEQ_STEP_EN
    tick();
`endif
    total++;
    if (instr_req !== 1'b1 || instr_addr !== 8'd1) begin
      bad++; $display("FAIL rst_pre: req=%0b addr=%0d, want 1 1", instr_req, instr_addr);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (instr_req !== 1'b0 || busy !== 1'b0 || instr_addr !== 8'd0 || halted !== 1'b0 ||
        rd_data !== 16'h0 || rd_valid !== 1'b0 || opcode !== 16'h0) begin
      bad++; $display("FAIL rst_mid: req=%0b busy=%0b addr=%0d rd=%0h, want 0 0 0 0", instr_req, busy, instr_addr, rd_data);
    end
    reset = 1'b0;
    wait_n = 0; wcnt = 0;
    instr_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] ea;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ea = 2'(i);
      total++;
      if (instr_req2 !== 1'b1 || instr_addr2 !== ea || opcode2 !== 16'h0) begin
        bad++; $display("FAIL wrap_fetch%0d: req=%0b addr=%0d op=%0h, want 1 %0d 0", i, instr_req2, instr_addr2, opcode2, ea);
      end
      tick();
      total++;
      if (opcode2 !== 16'h0 || instr_req2 !== 1'b0 || busy2 !== 1'b1) begin
        bad++; $display("FAIL wrap_exec%0d: op=%0h req=%0b busy=%0b, want 0 0 1", i, opcode2, instr_req2, busy2);
      end
`ifdef REGFILE_SEQ_STEP_EN
      for (int j = 0; j < 2; j++) begin
        tick();
        total++;
        if (busy2 !== 1'b1 || instr_req2 !== 1'b0) begin
          bad++; $display("FAIL wrap_pause%0d: busy=%0b req=%0b, want 1 0", i, busy2, instr_req2);
        end
      end
      step2 = 1'b1; tick(); step2 = 1'b0;
`else
      tick();
`endif
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    instr_valid = 1'b0; instr_data = '0; read_data_reg = '0;
    instr_valid2 = 1'b0; instr_data2 = '0;
    wait_n = 0; wcnt = 0;
`ifdef REGFILE_SEQ_STEP_EN
    step = 1'b1; step2 = 1'b0;
`endif
    test_reset();
    test_write_halt();
    test_alu();
    test_read();
    test_wait();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
